// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its busy scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t / xlen_t  : address and data types for the default configuration
//   onehot_dec           : address to one-hot decoder (supports up to DEC_W registers)
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int DEC_W     = 256;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  // One-hot decode of an 8-bit address; callers truncate the result to NREGS.
  function automatic logic [DEC_W-1:0] onehot_dec(input logic [7:0] a);
    logic [DEC_W-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   we, wa            : writeback enables/addresses (each clears busy[wa])
//   iss_en, iss_addr  : issue port (sets busy[iss_addr]; wins over a same-edge clear)
//   busy              : current busy vector
//   busy_cnt          : registered popcount of busy, updated on the same edge
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NWR-1:0]          we,
  input  logic [NWR-1:0][AW-1:0]  wa,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic [NREGS-1:0]        busy,
  output logic [AW:0]             busy_cnt
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr_mask, set_mask;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    clr_mask = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) clr_mask = clr_mask | NREGS'(onehot_dec(8'(wa[j])));
    end
    set_mask = iss_en ? NREGS'(onehot_dec(8'(iss_addr))) : '0;
    // Set is applied after clear so a newly issued producer keeps the register busy.
    busy_d = (busy_q & ~clr_mask) | set_mask;
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    // Count is taken from the next-state vector so it tracks busy on the same edge.
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and cleared busy) to the read ports.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   ra / rd / rbusy   : NRD combinational read ports (address, data, busy flag)
//   we / wa / wd      : NWR synchronous write ports; highest port index wins
//   iss_en / iss_addr : issue port marking a destination busy
//   busy_cnt          : registered number of busy registers
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   ra,
  output logic [NRD-1:0][XLEN-1:0] rd,
  output logic [NRD-1:0]           rbusy,
  input  logic [NWR-1:0]           we,
  input  logic [NWR-1:0][AW-1:0]   wa,
  input  logic [NWR-1:0][XLEN-1:0] wd,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [AW:0]              busy_cnt
);

  localparam bit ZR = (ZERO_R0 != 0);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [XLEN-1:0]  rf_d [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Ports are applied in ascending order so the highest index wins a collision.
  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && !(ZR && (wa[j] == '0))) rf_d[wa[j]] = wd[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads are forced to zero while reset is held and for r0 when it is hardwired.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd[i]    = '0;
      rbusy[i] = 1'b0;
      if (!reset && !(ZR && (ra[i] == '0))) begin
        rd[i]    = rf_q[ra[i]];
        rbusy[i] = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
        // Later ports override earlier ones, matching write priority.
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j] == ra[i])) begin
            rd[i]    = wd[j];
            rbusy[i] = iss_en && (iss_addr == ra[i]);
          end
        end
`endif
      end
    end
  end

endmodule
